// File: rtl/regfile_wb_if.sv
// regfile_wb_if: read, issue and ALU result signals between the pipeline and the register file
interface regfile_wb_if #(parameter int XLEN = 32);
  logic [4:0] rs1_addr;
  logic [4:0] rs2_addr;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic issue_valid;
  logic issue_writes;
  logic [4:0] issue_rd;
  logic issue_ready;
  logic alu_valid;
  logic [4:0] alu_rd;
  logic rd_write_control;
  logic [XLEN-1:0] rd_write_val;
  logic [31:0] pending;
  modport master (
    output rs1_addr, rs2_addr, issue_valid, issue_writes, issue_rd,
    output alu_valid, alu_rd, rd_write_control, rd_write_val,
    input rs1_val, rs2_val, issue_ready, pending
  );
  modport slave (
    input rs1_addr, rs2_addr, issue_valid, issue_writes, issue_rd,
    input alu_valid, alu_rd, rd_write_control, rd_write_val,
    output rs1_val, rs2_val, issue_ready, pending
  );
endinterface

// File: rtl/regfile_wb.sv
// regfile_wb: RV32I register file with a registered writeback slot, read bypass and RAW/WAW scoreboard
module regfile_wb #(parameter int XLEN = 32) (
  input logic CLK,
  input logic RST_N,
  regfile_wb_if.slave bus
);
  logic [XLEN-1:0] regs_q [1:31];
  logic wb_valid_q, wb_valid_d;
  logic [4:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_val_q, wb_val_d;
  logic [31:0] pending_q, pending_d, set_mask, clr_mask;
  logic ready;
  assign bus.rs1_val = (bus.rs1_addr == 5'd0) ? '0 :
                       (wb_valid_q && wb_rd_q == bus.rs1_addr) ? wb_val_q : regs_q[bus.rs1_addr];
  assign bus.rs2_val = (bus.rs2_addr == 5'd0) ? '0 :
                       (wb_valid_q && wb_rd_q == bus.rs2_addr) ? wb_val_q : regs_q[bus.rs2_addr];
  // pending[0] is never set, so x0 can never stall issue
  assign ready = ~(pending_q[bus.rs1_addr] | pending_q[bus.rs2_addr] |
                   (bus.issue_writes & pending_q[bus.issue_rd]));
  assign bus.issue_ready = ready;
  assign bus.pending = pending_q;
  always_comb begin
    set_mask = (bus.issue_valid && ready && bus.issue_writes && bus.issue_rd != 5'd0) ?
               32'd1 << bus.issue_rd : '0;
    clr_mask = bus.alu_valid ? 32'd1 << bus.alu_rd : '0;
    pending_d = (pending_q & ~clr_mask) | set_mask;
    wb_valid_d = bus.alu_valid && bus.rd_write_control && bus.alu_rd != 5'd0;
    wb_rd_d = bus.alu_rd;
    wb_val_d = bus.rd_write_val;
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wb_valid_q <= 1'b0;
      wb_rd_q <= '0;
      wb_val_q <= '0;
      pending_q <= '0;
      for (int i = 1; i < 32; i++) regs_q[i] <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_rd_q <= wb_rd_d;
      wb_val_q <= wb_val_d;
      pending_q <= pending_d;
      if (wb_valid_q) regs_q[wb_rd_q] <= wb_val_q;
    end
  end
endmodule

// File: tb/tb_regfile_wb.sv
// tb_regfile_wb: directed vector table, multi-cycle sequences and a randomized run against an architectural model
module tb_regfile_wb;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int checks = 0;
  int errors = 0;
  regfile_wb_if #(.XLEN(32)) bus();
  regfile_wb #(.XLEN(32)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));
  always #5 CLK = ~CLK;

  typedef struct {
    int unsigned rs1, rs2, iv, iw, ird, av, ard, wc, wval;
    int unsigned e1, e2, er, ep;
  } vec_t;
  vec_t vt[19];

  logic [31:0] arch [32];
  logic [31:0] mpend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int unsigned rs1, rs2, iv, iw, ird, av, ard, wc, wval);
    bus.rs1_addr = 5'(rs1);
    bus.rs2_addr = 5'(rs2);
    bus.issue_valid = iv[0];
    bus.issue_writes = iw[0];
    bus.issue_rd = 5'(ird);
    bus.alu_valid = av[0];
    bus.alu_rd = 5'(ard);
    bus.rd_write_control = wc[0];
    bus.rd_write_val = wval;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] mread(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : arch[a];
  endfunction

  function automatic logic mready();
    return !(mpend[bus.rs1_addr] || mpend[bus.rs2_addr] || (bus.issue_writes && mpend[bus.issue_rd]));
  endfunction

  // architectural view: a result captured at an edge is visible to every read after that edge
  task automatic model_edge();
    logic acc;
    acc = bus.issue_valid && mready();
    if (!RST_N) begin
      for (int i = 0; i < 32; i++) arch[i] = 32'd0;
      mpend = 32'd0;
    end else begin
      if (bus.alu_valid) mpend[bus.alu_rd] = 1'b0;
      if (acc && bus.issue_writes && bus.issue_rd != 5'd0) mpend[bus.issue_rd] = 1'b1;
      if (bus.alu_valid && bus.rd_write_control && bus.alu_rd != 5'd0) arch[bus.alu_rd] = bus.rd_write_val;
    end
  endtask

  initial begin
    vt[0]  = '{5, 0, 0, 0, 0, 1, 5, 1, 32'hDEADBEEF, 0, 0, 1, 0};
    vt[1]  = '{5, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 1, 0};
    vt[2]  = '{5, 5, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 1, 0};
    vt[3]  = '{0, 0, 1, 1, 0, 1, 0, 1, 32'h12345678, 0, 0, 1, 0};
    vt[4]  = '{0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 1, 0};
    vt[5]  = '{0, 0, 1, 1, 7, 0, 0, 0, 0, 0, 0, 1, 0};
    vt[6]  = '{0, 7, 1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 32'h80};
    vt[7]  = '{0, 7, 1, 1, 8, 1, 7, 1, 32'h55, 0, 0, 0, 32'h80};
    vt[8]  = '{0, 7, 1, 1, 8, 0, 0, 0, 0, 0, 32'h55, 1, 0};
    vt[9]  = '{0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 32'h55, 1, 32'h100};
    vt[10] = '{0, 0, 1, 1, 9, 0, 0, 0, 0, 0, 0, 1, 32'h100};
    vt[11] = '{0, 0, 1, 1, 9, 1, 9, 0, 0, 0, 0, 0, 32'h300};
    vt[12] = '{0, 0, 1, 1, 9, 0, 0, 0, 0, 0, 0, 1, 32'h100};
    vt[13] = '{0, 0, 0, 0, 0, 1, 8, 0, 0, 0, 0, 1, 32'h300};
    vt[14] = '{0, 0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 1, 32'h200};
    vt[15] = '{3, 0, 0, 0, 0, 1, 3, 0, 32'hFFFF, 0, 0, 0, 32'h208};
    vt[16] = '{3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h200};
    vt[17] = '{0, 0, 1, 1, 12, 1, 12, 0, 0, 0, 0, 1, 32'h200};
    vt[18] = '{5, 7, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 32'h55, 1, 32'h1200};

    // reset held for two edges under random inputs
    RST_N = 1'b0;
    for (int c = 0; c < 2; c++) begin
      drive($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
      tick();
    end
    RST_N = 1'b1;
    idle();
    for (int i = 0; i < 32; i++) begin
      bus.rs1_addr = 5'(i);
      bus.rs2_addr = 5'(31 - i);
      #1;
      chk("reset_rs1", bus.rs1_val, 32'd0);
      chk("reset_rs2", bus.rs2_val, 32'd0);
    end
    chk("reset_pending", bus.pending, 32'd0);
    chk("reset_ready", {31'd0, bus.issue_ready}, 32'd1);

    for (int k = 0; k < 19; k++) begin
      drive(vt[k].rs1, vt[k].rs2, vt[k].iv, vt[k].iw, vt[k].ird, vt[k].av, vt[k].ard, vt[k].wc, vt[k].wval);
      #1;
      chk($sformatf("vec%0d_rs1", k), bus.rs1_val, vt[k].e1);
      chk($sformatf("vec%0d_rs2", k), bus.rs2_val, vt[k].e2);
      chk($sformatf("vec%0d_ready", k), {31'd0, bus.issue_ready}, vt[k].er);
      chk($sformatf("vec%0d_pending", k), bus.pending, vt[k].ep);
      tick();
    end

    // reset while the writeback slot holds a result for x4
    drive(0, 0, 0, 0, 0, 1, 4, 1, 32'hAAAA5555);
    tick();
    idle();
    bus.rs1_addr = 5'd4;
    #1;
    chk("slot_x4_bypass", bus.rs1_val, 32'hAAAA5555);
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    bus.rs1_addr = 5'd4;
    bus.rs2_addr = 5'd5;
    #1;
    chk("midreset_x4", bus.rs1_val, 32'd0);
    chk("midreset_x5", bus.rs2_val, 32'd0);
    chk("midreset_pending", bus.pending, 32'd0);
    chk("midreset_ready", {31'd0, bus.issue_ready}, 32'd1);
    tick();
    bus.rs1_addr = 5'd4;
    #1;
    chk("midreset_x4_late", bus.rs1_val, 32'd0);

    for (int i = 0; i < 32; i++) arch[i] = 32'd0;
    mpend = 32'd0;
    for (int c = 0; c < 3000; c++) begin
      RST_N = ($urandom_range(0, 99) != 0);
      drive($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 2) != 0, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
            $urandom);
      #1;
      chk("rand_rs1", bus.rs1_val, mread(bus.rs1_addr));
      chk("rand_rs2", bus.rs2_val, mread(bus.rs2_addr));
      chk("rand_ready", {31'd0, bus.issue_ready}, {31'd0, mready()});
      chk("rand_pending", bus.pending, mpend);
      model_edge();
      tick();
    end
    RST_N = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_wb.md
# regfile_wb

Integer register file and writeback stage for the bootcamp RV32I core. It sits on both sides of the ALU: it supplies `rs1_val`/`rs2_val` to the ALU and consumes the ALU's `rd_write_control`/`rd_write_val` one cycle later through a registered writeback slot. A per-register pending scoreboard stalls issue on RAW and WAW hazards. A bypass path makes a result readable one cycle after the ALU produces it.

## Interface
Parameters:
- `XLEN`, default 32: data width; the register count is fixed at 32 and the index width at 5.

Ports:
- `CLK`  in  1: single clock; all state updates on the rising edge.
- `RST_N`  in  1: reset, synchronous, active-low.
- `rs1_addr`  in  5: read port 1 index.
- `rs2_addr`  in  5: read port 2 index.
- `rs1_val`  out  XLEN: read port 1 data, combinational.
- `rs2_val`  out  XLEN: read port 2 data, combinational.
- `issue_valid`  in  1: decoder presents an instruction.
- `issue_writes`  in  1: the presented instruction writes rd.
- `issue_rd`  in  5: destination index of the presented instruction.
- `issue_ready`  out  1: no hazard; the instruction is accepted when `issue_valid && issue_ready`.
- `alu_valid`  in  1: ALU result present this cycle.
- `alu_rd`  in  5: destination of the ALU result.
- `rd_write_control`  in  1: ALU write enable.
- `rd_write_val`  in  XLEN: ALU result.
- `pending`  out  32: scoreboard bits, for debug and the bench; bit 0 is always 0.

## Operation
- **State:**
  - `regs[1..31]`, each XLEN wide.
  - writeback slot: `wb_valid`, `wb_rd`, `wb_val`.
  - `pending[31:0]`.
- **Reset** (`RST_N`=0 at an edge):
  - all `regs`, `wb_*` and `pending` cleared to 0.
  - outputs during and after reset: `rs*_val`=0 and `pending`=0. `issue_ready`=1 follows from the empty scoreboard.
  - Reset mid-operation discards the slot contents and all pending bits.
- **Read**, per port:
  - index 0 returns 0.
  - if `wb_valid && wb_rd==addr`, returns `wb_val` (bypass).
  - otherwise returns `regs[addr]`.
- **Capture:**
  - An edge with `alu_valid && rd_write_control && alu_rd!=0` loads the slot: `wb_valid`=1, `wb_rd`=`alu_rd`, `wb_val`=`rd_write_val`.
  - Otherwise `wb_valid`=0.
- **Commit:** at every edge with `wb_valid`=1, `regs[wb_rd]`←`wb_val`. Commit and a new capture happen on the same edge without conflict.
- **Scoreboard:**
  - An accepted issue with `issue_writes`=1 and `issue_rd!=0` sets `pending[issue_rd]`.
  - Any edge with `alu_valid` clears `pending[alu_rd]`, regardless of `rd_write_control`. This also covers branches and stores that reached the ALU.
  - If set and clear hit the same index on one edge, set wins.
  - Index 0 is never set.
- **issue_ready:** combinational, from registered `pending` only (no same-cycle clear forwarding). It is 0 when any of the following holds:
  - `pending[rs1_addr]`=1
  - `pending[rs2_addr]`=1
  - `issue_writes` and `pending[issue_rd]`=1
  - Index 0 never causes a stall.
- **Ignored inputs:**
  - `alu_valid`=1 for a non-pending rd: accepted; the clear is a no-op.
  - x0 writes are dropped at capture.

## Timing
- Result presented in cycle N:
  - captured at the end of N.
  - readable via bypass during N+1.
  - in `regs` at the end of N+1, readable from the array from N+2.
- The pending bit drops at the end of N. A dependent instruction stalled in N sees `issue_ready`=1 in N+1 and reads the bypassed value.
- Read ports are zero-latency. No path from `rd_write_val` to `rs*_val` within one cycle.
- Back-to-back results to the same rd in N and N+1: the bypass returns the newer value in N+2, and `regs` ends holding the newer value.
- The block accepts one result per cycle and never back-pressures the ALU.

## Test plan
- **Reset:** hold `RST_N`=0 for 2 cycles with random inputs, then read every index. Required: all reads 0, `pending`=0, `issue_ready`=1.
- **Write/read latency:** `alu_valid`=1, `alu_rd`=5, `rd_write_control`=1, `rd_write_val`=0xDEADBEEF in cycle N. Required: `rs1_addr`=5 reads the old value 0 in N, 0xDEADBEEF in N+1 (bypass), and 0xDEADBEEF in N+2 (array).
- **x0:** write 0x12345678 to rd=0 and issue with `issue_rd`=0. Required: reads of x0 stay 0, `pending[0]`=0, no stall.
- **RAW stall:** issue writing x7 in cycle 1, then present an instruction with `rs2_addr`=7. Required: `issue_ready`=0 until the ALU result for x7 (0x55) is captured, `issue_ready`=1 the next cycle, and `rs2_val`=0x55 via bypass.
- **WAW and set/clear collision:** x9 pending; on one edge the ALU clears x9 while a new issue for x9 is attempted. Required: the issue stalls that cycle (`issue_ready`=0), is accepted the next cycle, and `pending[9]`=1 afterwards.
- **No-write result and mid-operation reset:** `alu_valid`=1, `rd_write_control`=0, `alu_rd`=3 with x3 pending. Required: `pending[3]` clears and `regs[3]` is unchanged. Then assert reset with `wb_valid`=1 for x4. Required: after reset x4 reads 0.
